// File: rtl/axis_frame_pad_trunc_if.sv
// Byte-wide AXI4-Stream bundle shared by the frame conditioner and its neighbours.
// Latency: none (wires only).
// Backpressure: tready flows from slave to master; all other signals flow master to slave.
interface axis_frame_pad_trunc_if #(
    parameter int USER_WIDTH = 1
);
    logic [7:0]            tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_pad_trunc.sv
// TX frame conditioner: zero-pads short frames, truncates long ones, reports per-frame status.
// Latency: 1 cycle input to output through a single registered output stage.
// Backpressure: input ready follows output ready except while padding (0) or discarding a tail (1).
module axis_frame_pad_trunc #(
    parameter int USER_WIDTH     = 1,
    parameter int MIN_LENGTH     = 60,
    parameter int MAX_LENGTH     = 1514,
    parameter int LEN_WIDTH      = 16,
    parameter bit TRUNC_MARK_BAD = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    axis_frame_pad_trunc_if.slave    s_axis,
    axis_frame_pad_trunc_if.master   m_axis,
    output logic                     status_valid,
    output logic [LEN_WIDTH-1:0]     status_frame_len,
    output logic                     status_padded,
    output logic                     status_truncated
);

    localparam logic [LEN_WIDTH-1:0] MIN_L    = LEN_WIDTH'(MIN_LENGTH);
    localparam logic [LEN_WIDTH-1:0] MAX_L    = LEN_WIDTH'(MAX_LENGTH);
    localparam bit                   TRUNC_EN = (MAX_LENGTH != 0);

    // A nonzero maximum below the minimum would make padded frames illegal.
    generate
        if (MAX_LENGTH != 0 && MAX_LENGTH < MIN_LENGTH) begin : g_bad_len
            $error("axis_frame_pad_trunc: MAX_LENGTH must be 0 or >= MIN_LENGTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_TRANSFER,
        ST_PAD,
        ST_TRUNCATE
    } state_e;

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [USER_WIDTH-1:0] saved_user_q, saved_user_d;
    logic [7:0]            tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [USER_WIDTH-1:0] tuser_q, tuser_d;
    logic                  st_vld_q, st_vld_d;
    logic [LEN_WIDTH-1:0]  st_len_q, st_len_d;
    logic                  st_pad_q, st_pad_d;
    logic                  st_trunc_q, st_trunc_d;

    logic                  ord;
    logic                  s_rdy;
    logic [LEN_WIDTH-1:0]  cnt_inc;

    // Output register may take a new beat when empty or being drained this cycle.
    assign ord = m_axis.tready || !tvalid_q;

    // Saturating so an unbounded frame (no truncation) pins the length at all-ones.
    assign cnt_inc = (&count_q) ? count_q : count_q + LEN_WIDTH'(1);

    assign s_axis.tready    = s_rdy && !rst;
    assign m_axis.tdata     = tdata_q;
    assign m_axis.tvalid    = tvalid_q;
    assign m_axis.tlast     = tlast_q;
    assign m_axis.tuser     = tuser_q;
    assign status_valid     = st_vld_q;
    assign status_frame_len = st_len_q;
    assign status_padded    = st_pad_q;
    assign status_truncated = st_trunc_q;

    // Next-state, output-register load and status generation.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        saved_user_d = saved_user_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        st_vld_d     = 1'b0;
        st_len_d     = st_len_q;
        st_pad_d     = st_pad_q;
        st_trunc_d   = st_trunc_q;
        s_rdy        = 1'b0;

        unique case (state_q)
            ST_TRANSFER: begin
                s_rdy = ord;
                if (ord) begin
                    tvalid_d = s_axis.tvalid;
                    if (s_axis.tvalid) begin
                        tdata_d = s_axis.tdata;
                        tuser_d = s_axis.tuser;
                        tlast_d = 1'b0;
                        if (s_axis.tlast) begin
                            if (cnt_inc >= MIN_L) begin
                                tlast_d    = 1'b1;
                                st_vld_d   = 1'b1;
                                st_len_d   = cnt_inc;
                                st_pad_d   = 1'b0;
                                st_trunc_d = 1'b0;
                                count_d    = '0;
                            end else begin
                                // Sideband belongs on the real end of frame, after the pad.
                                tuser_d      = '0;
                                saved_user_d = s_axis.tuser;
                                count_d      = cnt_inc;
                                state_d      = ST_PAD;
                            end
                        end else if (TRUNC_EN && cnt_inc == MAX_L) begin
                            tlast_d = 1'b1;
                            if (TRUNC_MARK_BAD) begin
                                tuser_d[0] = 1'b1;
                            end
                            st_vld_d   = 1'b1;
                            st_len_d   = MAX_L;
                            st_pad_d   = 1'b0;
                            st_trunc_d = 1'b1;
                            count_d    = '0;
                            state_d    = ST_TRUNCATE;
                        end else begin
                            count_d = cnt_inc;
                        end
                    end
                end
            end

            ST_PAD: begin
                if (ord) begin
                    tvalid_d = 1'b1;
                    tdata_d  = 8'h00;
                    tuser_d  = '0;
                    tlast_d  = 1'b0;
                    if (cnt_inc == MIN_L) begin
                        tlast_d    = 1'b1;
                        tuser_d    = saved_user_q;
                        st_vld_d   = 1'b1;
                        st_len_d   = MIN_L;
                        st_pad_d   = 1'b1;
                        st_trunc_d = 1'b0;
                        count_d    = '0;
                        state_d    = ST_TRANSFER;
                    end else begin
                        count_d = cnt_inc;
                    end
                end
            end

            ST_TRUNCATE: begin
                // Tail bytes are swallowed without waiting on the output side.
                s_rdy = 1'b1;
                if (ord) begin
                    tvalid_d = 1'b0;
                end
                if (s_axis.tvalid && s_axis.tlast) begin
                    state_d = ST_TRANSFER;
                end
            end

            default: begin
                state_d = ST_TRANSFER;
            end
        endcase
    end

    // State, counter, output and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_TRANSFER;
            count_q      <= '0;
            saved_user_q <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= '0;
            st_vld_q     <= 1'b0;
            st_len_q     <= '0;
            st_pad_q     <= 1'b0;
            st_trunc_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            saved_user_q <= saved_user_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            st_vld_q     <= st_vld_d;
            st_len_q     <= st_len_d;
            st_pad_q     <= st_pad_d;
            st_trunc_q   <= st_trunc_d;
        end
    end

endmodule

// File: tb/tb_axis_frame_pad_trunc.sv
// Directed bench for axis_frame_pad_trunc with default parameters (MIN 60, MAX 1514).
// Latency: observes outputs on the falling edge; drives inputs 1 time unit after the rising edge.
// Backpressure: m_axis_tready is either held high or toggled randomly per cycle.
module tb_axis_frame_pad_trunc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_frame_pad_trunc_if #(.USER_WIDTH(1)) s_if();
    axis_frame_pad_trunc_if #(.USER_WIDTH(1)) m_if();

    logic        status_valid;
    logic [15:0] status_frame_len;
    logic        status_padded;
    logic        status_truncated;

    axis_frame_pad_trunc dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis           (s_if),
        .m_axis           (m_if),
        .status_valid     (status_valid),
        .status_frame_len (status_frame_len),
        .status_padded    (status_padded),
        .status_truncated (status_truncated)
    );

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;
    int hold_viol = 0;

    logic [7:0] out_dat[$];
    bit         out_last[$];
    bit         out_user[$];
    int         st_len[$];
    bit         st_pad[$];
    bit         st_trunc[$];

    logic [7:0] exp_dat[$];
    bit         exp_last[$];
    bit         exp_user[$];
    int         exp_len[$];
    bit         exp_pad[$];
    bit         exp_trunc[$];

    bit         prev_stall = 1'b0;
    bit         prev_rst = 1'b1;
    logic [7:0] prev_dat;
    logic       prev_last;
    logic       prev_user;

    // Sink back-pressure.
    always @(posedge clk) begin
        #1;
        m_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Capture accepted output beats, status pulses and hold-rule violations.
    always @(negedge clk) begin
        if (!rst && m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
            out_dat.push_back(m_if.tdata);
            out_last.push_back(m_if.tlast);
            out_user.push_back(m_if.tuser[0]);
        end
        if (!rst && status_valid === 1'b1) begin
            st_len.push_back(int'(status_frame_len));
            st_pad.push_back(status_padded);
            st_trunc.push_back(status_truncated);
        end
        if (prev_stall && !prev_rst) begin
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_dat ||
                m_if.tlast !== prev_last || m_if.tuser[0] !== prev_user)
                hold_viol++;
        end
        prev_stall = (m_if.tvalid === 1'b1) && (m_if.tready !== 1'b1);
        prev_dat   = m_if.tdata;
        prev_last  = m_if.tlast;
        prev_user  = m_if.tuser[0];
        prev_rst   = rst;
    end

    function automatic logic [7:0] pat(input int seed, input int i);
        return 8'(seed + i * 13);
    endfunction

    task automatic clear_all();
        out_dat.delete();  out_last.delete(); out_user.delete();
        st_len.delete();   st_pad.delete();   st_trunc.delete();
        exp_dat.delete();  exp_last.delete(); exp_user.delete();
        exp_len.delete();  exp_pad.delete();  exp_trunc.delete();
        hold_viol = 0;
    endtask

    // Reference model of one input frame's effect on the output (MIN 60, MAX 1514).
    task automatic expect_frame(input int len, input int seed, input bit ulast);
        int n;
        n = (len > 1514) ? 1514 : ((len < 60) ? 60 : len);
        for (int i = 0; i < n; i++) begin
            exp_dat.push_back((i < len) ? pat(seed, i) : 8'h00);
            exp_last.push_back(i == n - 1);
            if (i != n - 1)     exp_user.push_back(1'b0);
            else if (len > 1514) exp_user.push_back(1'b1);
            else                exp_user.push_back(ulast);
        end
        exp_len.push_back(n);
        exp_pad.push_back(len < 60);
        exp_trunc.push_back(len > 1514);
    endtask

    task automatic send_frame(input int len, input int seed, input bit ulast,
                              input int mark, output int stalls);
        int w;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            s_if.tdata  = pat(seed, i);
            s_if.tlast  = (i == len - 1);
            s_if.tuser  = (i == len - 1) ? ulast : 1'b0;
            s_if.tvalid = 1'b1;
            w = 0;
            @(negedge clk);
            while (s_if.tready !== 1'b1 && w < 5000) begin
                w++;
                @(negedge clk);
            end
            if (w >= 5000) begin
                checks++; errors++;
                $display("FAIL send_timeout beat %0d: s_axis_tready stuck at %b, required 1", i, s_if.tready);
                s_if.tvalid = 1'b0;
                return;
            end
            if (i >= mark) stalls += w;
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_out(input int n, output bit ok);
        int w;
        w = 0;
        while (out_dat.size() < n && w < 20000) begin
            @(negedge clk);
            w++;
        end
        ok = (out_dat.size() >= n);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        s_if.tdata = 8'h00; s_if.tlast = 1'b0; s_if.tuser = 1'b0; s_if.tvalid = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_if.tvalid); end
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", s_if.tready); end
        checks++; if (status_valid !== 1'b0) begin errors++; $display("FAIL reset_status_valid got %b want 0", status_valid); end
        checks++; if (status_frame_len !== 16'd0 || status_padded !== 1'b0 || status_truncated !== 1'b0) begin
            errors++; $display("FAIL reset_status_fields got %0d/%b/%b want 0/0/0", status_frame_len, status_padded, status_truncated);
        end
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL idle_tready got %b want 1", s_if.tready); end
    endtask

    task automatic test_pad_short();
        int st; bit ok; int bad;
        clear_all(); rand_rdy = 1'b0;
        send_frame(1, 8'hAB, 1'b0, 0, st);
        expect_frame(1, 8'hAB, 1'b0);
        wait_out(exp_dat.size(), ok);
        checks++; if (!ok || out_dat.size() != exp_dat.size()) begin errors++; $display("FAIL pad_short_count got %0d want %0d", out_dat.size(), exp_dat.size()); end
        else begin
            bad = -1;
            for (int i = 0; i < exp_dat.size(); i++)
                if (bad < 0 && (out_dat[i] !== exp_dat[i] || out_last[i] !== exp_last[i] || out_user[i] !== exp_user[i])) bad = i;
            checks++; if (bad >= 0) begin errors++; $display("FAIL pad_short_beat %0d got %h/%b/%b want %h/%b/%b", bad, out_dat[bad], out_last[bad], out_user[bad], exp_dat[bad], exp_last[bad], exp_user[bad]); end
        end
        checks++; if (st_len.size() != 1 || st_len[0] != 60 || st_pad[0] !== 1'b1 || st_trunc[0] !== 1'b0) begin
            errors++; $display("FAIL pad_short_status got n=%0d len=%0d pad=%b trunc=%b want n=1 len=60 pad=1 trunc=0", st_len.size(), (st_len.size() > 0) ? st_len[0] : -1, (st_pad.size() > 0) ? st_pad[0] : 1'b0, (st_trunc.size() > 0) ? st_trunc[0] : 1'b0);
        end
    endtask

    task automatic test_backpressure();
        int st; bit ok; int bad;
        clear_all(); rand_rdy = 1'b1;
        send_frame(64, 8'h11, 1'b0, 0, st);
        expect_frame(64, 8'h11, 1'b0);
        wait_out(exp_dat.size(), ok);
        rand_rdy = 1'b0;
        checks++; if (!ok || out_dat.size() != exp_dat.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", out_dat.size(), exp_dat.size()); end
        else begin
            bad = -1;
            for (int i = 0; i < exp_dat.size(); i++)
                if (bad < 0 && (out_dat[i] !== exp_dat[i] || out_last[i] !== exp_last[i] || out_user[i] !== exp_user[i])) bad = i;
            checks++; if (bad >= 0) begin errors++; $display("FAIL bp_beat %0d got %h/%b/%b want %h/%b/%b", bad, out_dat[bad], out_last[bad], out_user[bad], exp_dat[bad], exp_last[bad], exp_user[bad]); end
        end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold got %0d violations want 0", hold_viol); end
        checks++; if (st_len.size() != 1 || st_len[0] != 64 || st_pad[0] !== 1'b0 || st_trunc[0] !== 1'b0) begin
            errors++; $display("FAIL bp_status got n=%0d len=%0d want n=1 len=64 flags 0", st_len.size(), (st_len.size() > 0) ? st_len[0] : -1);
        end
    endtask

    task automatic test_truncate();
        int st; int st2; bit ok; int bad;
        clear_all(); rand_rdy = 1'b1;
        send_frame(1600, 8'h22, 1'b0, 1514, st);
        send_frame(60, 8'h33, 1'b0, 0, st2);
        expect_frame(1600, 8'h22, 1'b0);
        expect_frame(60, 8'h33, 1'b0);
        wait_out(exp_dat.size(), ok);
        rand_rdy = 1'b0;
        checks++; if (st != 0) begin errors++; $display("FAIL trunc_drop_stalls got %0d want 0", st); end
        checks++; if (!ok || out_dat.size() != exp_dat.size()) begin errors++; $display("FAIL trunc_count got %0d want %0d", out_dat.size(), exp_dat.size()); end
        else begin
            bad = -1;
            for (int i = 0; i < exp_dat.size(); i++)
                if (bad < 0 && (out_dat[i] !== exp_dat[i] || out_last[i] !== exp_last[i] || out_user[i] !== exp_user[i])) bad = i;
            checks++; if (bad >= 0) begin errors++; $display("FAIL trunc_beat %0d got %h/%b/%b want %h/%b/%b", bad, out_dat[bad], out_last[bad], out_user[bad], exp_dat[bad], exp_last[bad], exp_user[bad]); end
        end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL trunc_hold got %0d violations want 0", hold_viol); end
        checks++; if (st_len.size() != 2) begin errors++; $display("FAIL trunc_status_count got %0d want 2", st_len.size()); end
        else begin
            for (int k = 0; k < 2; k++) begin
                checks++; if (st_len[k] != exp_len[k] || st_pad[k] !== exp_pad[k] || st_trunc[k] !== exp_trunc[k]) begin
                    errors++; $display("FAIL trunc_status%0d got %0d/%b/%b want %0d/%b/%b", k, st_len[k], st_pad[k], st_trunc[k], exp_len[k], exp_pad[k], exp_trunc[k]);
                end
            end
        end
    endtask

    task automatic test_exact_bounds();
        int st; bit ok; int bad;
        clear_all(); rand_rdy = 1'b0;
        send_frame(1514, 8'h44, 1'b0, 0, st);
        send_frame(60, 8'h55, 1'b1, 0, st);
        expect_frame(1514, 8'h44, 1'b0);
        expect_frame(60, 8'h55, 1'b1);
        wait_out(exp_dat.size(), ok);
        checks++; if (!ok || out_dat.size() != exp_dat.size()) begin errors++; $display("FAIL exact_count got %0d want %0d", out_dat.size(), exp_dat.size()); end
        else begin
            bad = -1;
            for (int i = 0; i < exp_dat.size(); i++)
                if (bad < 0 && (out_dat[i] !== exp_dat[i] || out_last[i] !== exp_last[i] || out_user[i] !== exp_user[i])) bad = i;
            checks++; if (bad >= 0) begin errors++; $display("FAIL exact_beat %0d got %h/%b/%b want %h/%b/%b", bad, out_dat[bad], out_last[bad], out_user[bad], exp_dat[bad], exp_last[bad], exp_user[bad]); end
        end
        checks++; if (st_len.size() != 2) begin errors++; $display("FAIL exact_status_count got %0d want 2", st_len.size()); end
        else begin
            for (int k = 0; k < 2; k++) begin
                checks++; if (st_len[k] != exp_len[k] || st_pad[k] !== exp_pad[k] || st_trunc[k] !== exp_trunc[k]) begin
                    errors++; $display("FAIL exact_status%0d got %0d/%b/%b want %0d/%b/%b", k, st_len[k], st_pad[k], st_trunc[k], exp_len[k], exp_pad[k], exp_trunc[k]);
                end
            end
        end
    endtask

    task automatic test_pad_user();
        int st; bit ok; int bad;
        clear_all(); rand_rdy = 1'b0;
        send_frame(10, 8'h66, 1'b1, 0, st);
        expect_frame(10, 8'h66, 1'b1);
        wait_out(exp_dat.size(), ok);
        checks++; if (!ok || out_dat.size() != exp_dat.size()) begin errors++; $display("FAIL pad_user_count got %0d want %0d", out_dat.size(), exp_dat.size()); end
        else begin
            bad = -1;
            for (int i = 0; i < exp_dat.size(); i++)
                if (bad < 0 && (out_dat[i] !== exp_dat[i] || out_last[i] !== exp_last[i] || out_user[i] !== exp_user[i])) bad = i;
            checks++; if (bad >= 0) begin errors++; $display("FAIL pad_user_beat %0d got %h/%b/%b want %h/%b/%b", bad, out_dat[bad], out_last[bad], out_user[bad], exp_dat[bad], exp_last[bad], exp_user[bad]); end
        end
        checks++; if (st_len.size() != 1 || st_len[0] != 60 || st_pad[0] !== 1'b1) begin
            errors++; $display("FAIL pad_user_status got n=%0d len=%0d want n=1 len=60 pad=1", st_len.size(), (st_len.size() > 0) ? st_len[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        int st; bit ok; int bad;
        clear_all(); rand_rdy = 1'b0;
        send_frame(5, 8'h77, 1'b0, 0, st);
        send_frame(70, 8'h88, 1'b1, 0, st);
        send_frame(1, 8'h99, 1'b0, 0, st);
        expect_frame(5, 8'h77, 1'b0);
        expect_frame(70, 8'h88, 1'b1);
        expect_frame(1, 8'h99, 1'b0);
        wait_out(exp_dat.size(), ok);
        checks++; if (!ok || out_dat.size() != exp_dat.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", out_dat.size(), exp_dat.size()); end
        else begin
            bad = -1;
            for (int i = 0; i < exp_dat.size(); i++)
                if (bad < 0 && (out_dat[i] !== exp_dat[i] || out_last[i] !== exp_last[i] || out_user[i] !== exp_user[i])) bad = i;
            checks++; if (bad >= 0) begin errors++; $display("FAIL b2b_beat %0d got %h/%b/%b want %h/%b/%b", bad, out_dat[bad], out_last[bad], out_user[bad], exp_dat[bad], exp_last[bad], exp_user[bad]); end
        end
        checks++; if (st_len.size() != 3) begin errors++; $display("FAIL b2b_status_count got %0d want 3", st_len.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (st_len[k] != exp_len[k] || st_pad[k] !== exp_pad[k] || st_trunc[k] !== exp_trunc[k]) begin
                    errors++; $display("FAIL b2b_status%0d got %0d/%b/%b want %0d/%b/%b", k, st_len[k], st_pad[k], st_trunc[k], exp_len[k], exp_pad[k], exp_trunc[k]);
                end
            end
        end
        checks++; if (status_valid !== 1'b0 || status_frame_len !== 16'd60 || status_padded !== 1'b1) begin
            errors++; $display("FAIL b2b_status_hold got %b/%0d/%b want 0/60/1", status_valid, status_frame_len, status_padded);
        end
    endtask

    task automatic test_reset_mid();
        int st; bit ok; int bad;
        clear_all(); rand_rdy = 1'b0;
        send_frame(30, 8'hC0, 1'b0, 0, st);
        s_if.tdata = pat(8'hC0, 30); s_if.tlast = 1'b0; s_if.tuser = 1'b0; s_if.tvalid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_mid_tready got %b want 0", s_if.tready); end
        @(posedge clk); #1;
        rst = 1'b0; s_if.tvalid = 1'b0;
        @(negedge clk);
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid got %b want 0", m_if.tvalid); end
        checks++; if (status_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_status got %b want 0", status_valid); end
        @(posedge clk); #1;
        clear_all();
        send_frame(70, 8'hD0, 1'b0, 0, st);
        expect_frame(70, 8'hD0, 1'b0);
        wait_out(exp_dat.size(), ok);
        checks++; if (!ok || out_dat.size() != exp_dat.size()) begin errors++; $display("FAIL rst_mid_count got %0d want %0d", out_dat.size(), exp_dat.size()); end
        else begin
            bad = -1;
            for (int i = 0; i < exp_dat.size(); i++)
                if (bad < 0 && (out_dat[i] !== exp_dat[i] || out_last[i] !== exp_last[i] || out_user[i] !== exp_user[i])) bad = i;
            checks++; if (bad >= 0) begin errors++; $display("FAIL rst_mid_beat %0d got %h/%b/%b want %h/%b/%b", bad, out_dat[bad], out_last[bad], out_user[bad], exp_dat[bad], exp_last[bad], exp_user[bad]); end
        end
        checks++; if (st_len.size() != 1 || st_len[0] != 70 || st_pad[0] !== 1'b0 || st_trunc[0] !== 1'b0) begin
            errors++; $display("FAIL rst_mid_status got n=%0d len=%0d want n=1 len=70 flags 0", st_len.size(), (st_len.size() > 0) ? st_len[0] : -1);
        end
    endtask

    initial begin
        s_if.tdata = 8'h00; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        test_reset();
        test_pad_short();
        test_backpressure();
        test_truncate();
        test_exact_bounds();
        test_pad_user();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
